// File: rtl/bnn_pkg.sv
// Shared width helpers and popcount for the binary-neural-network layer.
package bnn_pkg;

    localparam int unsigned PopMaxW = 64;
    localparam int unsigned PopCntW = $clog2(PopMaxW + 1);

    // Index width that never collapses to zero bits for single-entry arrays.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned in_w, input int unsigned beats);
        return $clog2(in_w * beats + 1);
    endfunction

    function automatic logic [PopCntW-1:0] popcount(input logic [PopMaxW-1:0] v);
        logic [PopCntW-1:0] c;
        c = '0;
        for (int i = 0; i < PopMaxW; i++) begin
            c = c + PopCntW'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bnn_layer_seq_if.sv
// Beat stream, config write and result handshakes of the BNN layer.
interface bnn_layer_seq_if
    import bnn_pkg::*;
#(
    parameter int unsigned IN_W    = 8,
    parameter int unsigned BEATS   = 4,
    parameter int unsigned NEURONS = 4
);
    localparam int unsigned CntW   = cnt_w(IN_W, BEATS);
    localparam int unsigned NeurW  = idx_w(NEURONS);
    localparam int unsigned BeatW  = idx_w(BEATS);
    localparam int unsigned WDataW = max_u(IN_W, CntW);

    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               w_valid;
    logic               w_ready;
    logic               w_thr;
    logic [NeurW-1:0]   w_neuron;
    logic [BeatW-1:0]   w_beat;
    logic [WDataW-1:0]  w_data;
    logic               out_valid;
    logic               out_ready;
    logic [NEURONS-1:0] out_bits;

    modport master (
        output in_valid, in_data, w_valid, w_thr, w_neuron, w_beat, w_data, out_ready,
        input  in_ready, w_ready, out_valid, out_bits
    );

    modport slave (
        input  in_valid, in_data, w_valid, w_thr, w_neuron, w_beat, w_data, out_ready,
        output in_ready, w_ready, out_valid, out_bits
    );

endinterface

// File: rtl/bnn_xnor_popcount.sv
// One neuron's per-beat match count: popcount of XNOR(input word, weight word).
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned CNT_W = 6
) (
    input  logic [IN_W-1:0]  a_i,
    input  logic [IN_W-1:0]  b_i,
    output logic [CNT_W-1:0] match_o
);
    logic [IN_W-1:0]    eq;
    logic [PopMaxW-1:0] eq_wide;

    // Extend after the inversion so the padding bits stay zero.
    assign eq      = ~(a_i ^ b_i);
    assign eq_wide = PopMaxW'(eq);
    assign match_o = CNT_W'(popcount(eq_wide));

endmodule

// File: rtl/bnn_layer_seq.sv
// NEURONS parallel XNOR-popcount neurons over a BEATS-word input sample with
// loadable weights/thresholds and valid/ready flow control.
module bnn_layer_seq
    import bnn_pkg::*;
#(
    parameter int unsigned IN_W    = 8,
    parameter int unsigned BEATS   = 4,
    parameter int unsigned NEURONS = 4
) (
    input logic            clk,
    input logic            rst,
    bnn_layer_seq_if.slave bus
);
    localparam int unsigned      CntW     = cnt_w(IN_W, BEATS);
    localparam int unsigned      BeatW    = idx_w(BEATS);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

    logic [IN_W-1:0]    weight_q [NEURONS][BEATS];
    logic [CntW-1:0]    thr_q    [NEURONS];
    logic [CntW-1:0]    acc_q    [NEURONS];
    logic [CntW-1:0]    acc_d    [NEURONS];
    logic [CntW-1:0]    match    [NEURONS];
    logic [CntW-1:0]    sum      [NEURONS];
    logic [NEURONS-1:0] fire;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic               out_valid_q, out_valid_d;
    logic [NEURONS-1:0] out_bits_q, out_bits_d;
    logic               last_beat, in_ready, w_ready, in_fire, w_fire;

    // Only the final beat stalls, and only if it would clobber an unconsumed result.
    assign last_beat     = (beat_q == LastBeat);
    assign in_ready      = !(last_beat && out_valid_q && !bus.out_ready);
    assign w_ready       = (beat_q == '0);
    assign in_fire       = bus.in_valid && in_ready;
    assign w_fire        = bus.w_valid && w_ready;
    assign bus.in_ready  = in_ready;
    assign bus.w_ready   = w_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = out_bits_q;

    for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
        bnn_xnor_popcount #(
            .IN_W  (IN_W),
            .CNT_W (CntW)
        ) u_pc (
            .a_i     (bus.in_data),
            .b_i     (weight_q[n][beat_q]),
            .match_o (match[n])
        );
        assign sum[n]  = acc_q[n] + match[n];
        assign fire[n] = (sum[n] >= thr_q[n]);
    end

    always_comb begin
        beat_d      = beat_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_fire) begin
            if (last_beat) begin
                beat_d      = '0;
                acc_d       = '{default: '0};
                out_valid_d = 1'b1;
                out_bits_d  = fire;
            end else begin
                beat_d = beat_q + 1'b1;
                acc_d  = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            acc_q       <= '{default: '0};
            thr_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            for (int n = 0; n < NEURONS; n++) begin
                for (int b = 0; b < BEATS; b++) begin
                    weight_q[n][b] <= '0;
                end
            end
        end else begin
            beat_q      <= beat_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            if (w_fire && (32'(bus.w_neuron) < NEURONS)) begin
                if (bus.w_thr) begin
                    thr_q[bus.w_neuron] <= bus.w_data[CntW-1:0];
                end else if (32'(bus.w_beat) < BEATS) begin
                    weight_q[bus.w_neuron][bus.w_beat] <= bus.w_data[IN_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Randomised and directed bench for bnn_layer_seq against a sample-level reference model.
module tb_bnn_layer_seq;
    localparam int unsigned IN_W    = 8;
    localparam int unsigned BEATS   = 4;
    localparam int unsigned NEURONS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    bnn_layer_seq_if #(.IN_W(IN_W), .BEATS(BEATS), .NEURONS(NEURONS)) bus ();

    bnn_layer_seq #(.IN_W(IN_W), .BEATS(BEATS), .NEURONS(NEURONS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: whole-sample view, weights snapshotted when a sample starts.
    logic [7:0]  m_w     [4][4];
    logic [7:0]  m_snap  [4][4];
    logic [7:0]  m_beats [4];
    int unsigned m_thr   [4];
    int unsigned m_cnt;
    logic        m_ov;
    logic [3:0]  m_bits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] ref_result();
        logic [3:0] bits;
        logic [7:0] eq;
        int unsigned s;
        for (int n = 0; n < 4; n++) begin
            s = 0;
            for (int b = 0; b < 4; b++) begin
                eq = ~(m_beats[b] ^ m_snap[n][b]);
                s += $countones(eq);
            end
            bits[n] = (s >= m_thr[n]);
        end
        return bits;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_thr[n] = 0;
            for (int b = 0; b < 4; b++) m_w[n][b] = 8'h00;
        end
        m_cnt  = 0;
        m_ov   = 1'b0;
        m_bits = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.w_valid   = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("rst_out_bits", 32'(bus.out_bits), 32'(m_bits));
        check("rst_w_ready", 32'(bus.w_ready), 32'd1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic cycle(input logic iv, input logic [7:0] d, input logic wv, input logic wt,
                         input logic [1:0] wn, input logic [1:0] wb, input logic [7:0] wd,
                         input logic ordy, output logic took);
        logic e_in, e_w, acc_in, acc_w;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.w_valid   = wv;
        bus.w_thr     = wt;
        bus.w_neuron  = wn;
        bus.w_beat    = wb;
        bus.w_data    = wd;
        bus.out_ready = ordy;
        #1;
        e_in = !(m_cnt == 3 && m_ov && !ordy);
        e_w  = (m_cnt == 0);
        check("in_ready", 32'(bus.in_ready), 32'(e_in));
        check("w_ready", 32'(bus.w_ready), 32'(e_w));
        acc_in = iv && e_in;
        acc_w  = wv && e_w;
        took   = acc_in;
        @(posedge clk);
        #1;
        if (m_ov && ordy) m_ov = 1'b0;
        if (acc_in) begin
            if (m_cnt == 0) m_snap = m_w;
            m_beats[m_cnt] = d;
            if (m_cnt == 3) begin
                m_bits = ref_result();
                m_ov   = 1'b1;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        if (acc_w) begin
            if (wt) m_thr[wn] = 32'(wd[5:0]);
            else    m_w[wn][wb] = wd;
        end
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("out_bits", 32'(bus.out_bits), 32'(m_bits));
    endtask

    task automatic beat(input logic [7:0] d, input logic ordy);
        logic took;
        cycle(1'b1, d, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00, ordy, took);
    endtask

    task automatic idle(input logic ordy);
        logic took;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00, ordy, took);
    endtask

    task automatic write(input logic wt, input logic [1:0] wn, input logic [1:0] wb,
                         input logic [7:0] wd);
        logic took;
        cycle(1'b0, 8'h00, 1'b1, wt, wn, wb, wd, 1'b1, took);
    endtask

    task automatic send_sample(input logic [31:0] s, input logic ordy);
        logic took;
        for (int b = 0; b < 4; b++) begin
            int tries = 0;
            do begin
                cycle(1'b1, s[8*b +: 8], 1'b0, 1'b0, 2'd0, 2'd0, 8'h00, ordy, took);
                tries++;
            end while (!took && tries < 16);
            if (!took) check("beat_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        logic took;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.w_valid   = 1'b0;
        bus.w_thr     = 1'b0;
        bus.w_neuron  = '0;
        bus.w_beat    = '0;
        bus.w_data    = '0;
        bus.out_ready = 1'b0;
        model_reset();

        // Zero weights, zero thresholds: everything fires.
        do_reset();
        send_sample(32'h0000_0000, 1'b1);
        check("t1_bits", 32'(bus.out_bits), 32'hF);
        idle(1'b1);

        // Neuron 1 weights all ones, threshold just above / at the sum of 16.
        for (int b = 0; b < 4; b++) write(1'b0, 2'd1, 2'(b), 8'hFF);
        write(1'b1, 2'd1, 2'd0, 8'd17);
        send_sample(32'h0000_FFFF, 1'b1);
        check("t2_thr17", 32'(bus.out_bits), 32'hD);
        idle(1'b1);
        write(1'b1, 2'd1, 2'd0, 8'd16);
        send_sample(32'h0000_FFFF, 1'b1);
        check("t2_thr16", 32'(bus.out_bits), 32'hF);
        idle(1'b1);

        // Backpressure: the final beat stalls until the pending result is consumed.
        send_sample(32'h0000_0000, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'h00, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, took);
        check("t3_stalled", 32'(took), 32'd0);
        check("t3_held_bits", 32'(bus.out_bits), 32'hD);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, took);
        check("t3_valid_kept", 32'(bus.out_valid), 32'd1);
        check("t3_new_bits", 32'(bus.out_bits), 32'hF);
        idle(1'b1);

        // A write mid-sample is refused.
        beat(8'h00, 1'b1);
        beat(8'h00, 1'b1);
        write(1'b1, 2'd0, 2'd0, 8'd40);
        beat(8'h00, 1'b1);
        beat(8'h00, 1'b1);
        check("t4_write_ignored", 32'(bus.out_bits), 32'hD);
        idle(1'b1);

        // Reset mid-sample drops partial sums and config.
        send_sample(32'h0000_0000, 1'b0);
        beat(8'h5A, 1'b0);
        beat(8'hA5, 1'b0);
        do_reset();
        send_sample(32'h3C00_FF81, 1'b1);
        check("t5_after_rst", 32'(bus.out_bits), 32'hF);
        idle(1'b1);

        // Threshold above fan-in never fires; threshold at fan-in needs a perfect match.
        write(1'b1, 2'd2, 2'd0, 8'd33);
        send_sample(32'h0000_0000, 1'b1);
        check("t6_thr33", 32'(bus.out_bits), 32'hB);
        idle(1'b1);
        write(1'b1, 2'd2, 2'd0, 8'd32);
        send_sample(32'h0000_0000, 1'b1);
        check("t6_thr32_hit", 32'(bus.out_bits), 32'hF);
        idle(1'b1);
        send_sample(32'h0000_0001, 1'b1);
        check("t6_thr32_miss", 32'(bus.out_bits), 32'hB);
        idle(1'b1);

        // Random traffic on all three channels.
        for (int i = 0; i < 600; i++) begin
            logic wt;
            wt = 1'($urandom);
            cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0, wt,
                  2'($urandom), 2'($urandom),
                  wt ? 8'($urandom_range(0, 34)) : 8'($urandom),
                  ($urandom % 3) != 0, took);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bnn_layer_seq.md
# bnn_layer_seq

Parametrised binary-neural-network layer: NEURONS XNOR-popcount neurons share one streamed input vector delivered as BEATS words of IN_W bits. Each neuron has its own loadable weights and threshold. The block extends the single fixed-width neuron with several things the old block lacked: configurable fan-in and neuron count, runtime weight and threshold loading, and valid/ready flow control. It sits between the input pad-mapping wrapper and the output/display logic.

## Interface
- IN_W, 8: bits per input beat.
- BEATS, 4: beats per sample; fan-in FAN = IN_W*BEATS.
- NEURONS, 4: neurons evaluated in parallel.
- CNT_W, derived: clog2(FAN+1), width of accumulators and thresholds.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted this cycle when in_valid & in_ready.
- in_data  in  IN_W  input bits (1 = +1, 0 = −1).
- w_valid  in  1  config write request.
- w_ready  out  1  config write accepted when w_valid & w_ready.
- w_thr  in  1  1 = write threshold, 0 = write weight word.
- w_neuron  in  clog2(NEURONS)  target neuron.
- w_beat  in  clog2(BEATS)  target weight word (ignored when w_thr=1).
- w_data  in  max(IN_W,CNT_W)  weight word [IN_W-1:0] or threshold [CNT_W-1:0].
- out_valid  out  1  result held.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_bits  out  NEURONS  bit n = neuron n fired.

## Operation
- Reset values:
  - all weights = 0; all thresholds = 0; accumulators = 0; beat_cnt = 0.
  - out_valid = 0; out_bits = 0.
- Per accepted beat b = beat_cnt, for each neuron n: match = popcount(~(in_data ^ W[n][b])).
- Non-final beat: acc[n] <= acc[n] + match; beat_cnt increments.
- Final beat (beat_cnt == BEATS-1):
  - out_bits[n] <= ((acc[n] + match) >= thr[n]).
  - out_valid <= 1; all acc cleared; beat_cnt <= 0.
- Arithmetic is unsigned CNT_W. The sum never exceeds FAN, so there is no overflow.
  - Threshold 0: neuron always fires.
  - Threshold > FAN: neuron never fires.
- States are implied by beat_cnt and out_valid:
  - IDLE: beat_cnt = 0.
  - ACCUM: beat_cnt ≠ 0.
  - The output register is independent of both, so ACCUM of the next sample overlaps a pending output.
- in_ready = !(beat_cnt == BEATS-1 && out_valid && !out_ready). Only the final beat stalls, and only when it would overwrite an unconsumed result.
- out_valid clears on consume, unless a final beat is accepted in the same cycle. In that case out_valid stays 1 and out_bits takes the new result.
- w_ready = (beat_cnt == 0). Writes while a sample is partially accumulated are refused and do not alter state.
  - A write accepted in cycle t is used by beats accepted from t+1 on.
  - A write and a first beat in the same cycle: the beat uses the old value.
- Reset mid-sample discards partial sums and any pending output. Weights and thresholds also return to 0.

## Timing
- Accumulation has one beat per cycle throughput and no bubbles between samples.
- Latency: out_valid rises on the clock edge that accepts the final beat, and is visible the following cycle.
- out_bits and out_valid stay stable while out_valid & !out_ready.
- All outputs are registered except in_ready and w_ready. These two are combinational from state and out_ready only, with no path from in_valid or w_valid.

## Structure
- Shared package bnn_pkg holds:
  - clog2-based width helpers;
  - the CNT_W derivation;
  - a popcount function.
- Sub-module bnn_xnor_popcount: combinational XNOR + popcount of one IN_W word, CNT_W result. It is instantiated NEURONS times.
- The top holds:
  - the weight array and threshold array;
  - the accumulators and beat counter;
  - the output register and handshake logic.

## Test plan
All cases use IN_W=8, BEATS=4, NEURONS=4.
- After reset, feed beats 0x00×4 → each match = 8, sum = 32 ≥ 0. out_bits = 4'hF one cycle after the 4th beat.
- Neuron 1: W = 0xFF×4, thr = 17; beats 0xFF,0xFF,0x00,0x00 → sum 16, bit1 = 0. Rewrite thr = 16 and repeat → bit1 = 1.
- Hold out_ready = 0 with a result pending:
  - the next sample's beats 0..2 are accepted;
  - in_ready = 0 on beat 3;
  - raise out_ready → beat 3 is accepted that cycle, out_valid stays 1 and out_bits updates.
- Issue a weight write after 2 beats → w_ready = 0. The write is ignored and the sample result equals the pre-write expectation.
- Assert rst after 2 beats → beat_cnt = 0, out_valid = 0. The next 4 beats give a result computed from zero weights and thresholds.
- Threshold 33 (> FAN) with all matches → neuron never fires. Threshold 32 → fires only on a perfect match.
